pwm_multichannel: RTL
=====================

# pwm_multichannel

Multi-channel PWM generator: the next generation of the single-channel PWM DAC driver. It drives CHANNELS outputs from one shared period counter. Each channel has a signed duty input with offset and saturation, and duty is double-buffered so updates only take effect at a period boundary. Each period runs edge-aligned or center-aligned, selected per period. The block sits after the DSP chain and feeds the RC-filtered PWM pins.

## Interface
- CHANNELS, 4: number of PWM outputs.
- DATA_WIDTH, 12: width of each channel's duty sample, two's-complement.
- COUNTER_WIDTH, 10: counter width; MAX = 2^COUNTER_WIDTH-1.
- OFFSET, 512: added to every sample to form the duty.
- clk  in  1  clock (one clock domain).
- rstn  in  1  reset, asynchronous, active-low.
- Enable  in  1  run/stop of the counter and outputs.
- Mode  in  1  0 = edge-aligned, 1 = center-aligned; sampled at period start.
- DataIn  in  CHANNELS*DATA_WIDTH  packed samples; channel k is at bits [k*DATA_WIDTH +: DATA_WIDTH].
- DataValid  in  1  one-cycle strobe; writes all channels of DataIn into the shadow.
- OverrunClr  in  1  clears Overrun.
- PWMOut  out  CHANNELS  registered PWM outputs.
- PeriodStart  out  1  registered one-cycle pulse per period.
- Overrun  out  1  sticky flag: a shadow word was overwritten before it was used.

## Operation
- Duty computation, per channel:
  - d = sign-extended DataIn + OFFSET, computed at DATA_WIDTH+2 bits.
  - Saturate d to the range 0..2^COUNTER_WIDTH; the result is COUNTER_WIDTH+1 bits.
  - 0 gives a constant low output; 2^COUNTER_WIDTH gives a constant high output.
- Shadow register:
  - DataValid loads the saturated duties into the shadow and sets `pending`.
  - If DataValid arrives while `pending` is already 1 (and the cycle is not a period start), the shadow is overwritten and Overrun is set.
- Period start (PS): a cycle with Enable=1, counter=0 and direction up.
  - At PS: if `pending`, active <= shadow and `pending` is cleared.
  - At PS, Mode is latched into the active mode.
- DataValid in the same cycle as PS:
  - The incoming word goes straight to active and `pending` is cleared.
  - If `pending` was 1, the old shadow is discarded and Overrun is set.
- Compare: the comparator sees the value being loaded at PS (bypass mux), so the whole new period uses the new duty and mode.
- Counter in edge mode: 0, 1, …, MAX, then wraps to 0. Period is 2^COUNTER_WIDTH cycles.
- Counter in center mode: up 0…MAX, then down MAX-1…1, then back to 0. Period is 2*MAX cycles.
- Output rule: PWMOut[k] = (counter < active_duty[k]), in both modes.
- Enable=0:
  - Counter is held at 0, direction up.
  - PWMOut = 0 and PeriodStart = 0.
  - Shadow loads and Overrun still operate.
  - The first enabled cycle is a PS.
- Overrun is sticky. OverrunClr clears it. If OverrunClr and a new overrun occur in the same cycle, set wins.

## Timing
- Reset values:
  - PWMOut = 0, PeriodStart = 0, Overrun = 0.
  - Counter = 0, direction up, active duty = 0, shadow = 0, `pending` = 0, active mode = edge.
- Latency:
  - PWMOut and PeriodStart at cycle t+1 reflect the counter and duty of cycle t. This is one cycle of latency.
  - DataValid to output: applied at the next PS, visible on PWMOut one cycle after that PS.
- Edge mode, duty D: PWMOut is high for D consecutive cycles per 2^COUNTER_WIDTH.
- Center mode, duty D with 0 < D ≤ MAX: PWMOut is high for 2D-1 cycles per 2*MAX. The pulse is centered on PS.
- Asserting rstn mid-period clears everything immediately, outputs included. After release, the first enabled cycle is a PS.
- Mode is never applied mid-period. A Mode change is visible only after the next PS.

## Test plan
- CHANNELS=4, COUNTER_WIDTH=10, OFFSET=512, edge mode, DataIn all 0 -> each PWMOut high for 512 of 1024 cycles; PeriodStart every 1024 cycles.
- Ch0=-600, ch1=+600, ch2=-512, ch3=+511 -> ch0 constant low (saturated 0), ch1 constant high (saturated 1024), ch2 constant low, ch3 high for 1023 of 1024 cycles.
- Center mode, duty sample 0 (D=512) -> high for 1023 of 2046 cycles; PeriodStart every 2046 cycles; pulse symmetric about PS.
- DataValid mid-period with 100, then with 200 before the next PS -> Overrun=1; the next period uses 200 (duty 712); OverrunClr returns Overrun to 0.
- DataValid exactly at a PS with no pending word -> new duty applies to that period; Overrun stays 0. Toggle Mode mid-period -> waveform changes only after the next PS.
- Enable low for 50 cycles mid-period, then rstn pulsed while running -> outputs 0 while disabled or in reset. After re-enable or reset release, PeriodStart fires on the first enabled cycle and the counter restarts at 0.

Source files
------------

// File: rtl/pwm_multichannel_if.sv
// Control, sample and status bundle between the DSP chain and the PWM generator.
interface pwm_multichannel_if #(
  parameter int CHANNELS   = 4,
  parameter int DATA_WIDTH = 12
);
  logic                           Enable;
  logic                           Mode;
  logic [CHANNELS*DATA_WIDTH-1:0] DataIn;
  logic                           DataValid;
  logic                           OverrunClr;
  logic [CHANNELS-1:0]            PWMOut;
  logic                           PeriodStart;
  logic                           Overrun;

  modport master (
    output Enable, Mode, DataIn, DataValid, OverrunClr,
    input  PWMOut, PeriodStart, Overrun
  );

  modport slave (
    input  Enable, Mode, DataIn, DataValid, OverrunClr,
    output PWMOut, PeriodStart, Overrun
  );
endinterface

// File: rtl/pwm_multichannel.sv
// Multi-channel PWM with one shared edge/center-aligned counter and
// double-buffered signed duty per channel (offset + saturation).
module pwm_multichannel #(
  parameter int CHANNELS      = 4,
  parameter int DATA_WIDTH    = 12,
  parameter int COUNTER_WIDTH = 10,
  parameter int OFFSET        = 512
) (
  input  logic               clk,
  input  logic               rstn,
  pwm_multichannel_if.slave  bus
);
  localparam int DW = DATA_WIDTH;
  localparam int CW = COUNTER_WIDTH;

  typedef logic [CW:0] duty_t;

  localparam logic [CW-1:0]        CNT_MAX  = '1;
  localparam logic [CW-1:0]        CNT_ONE  = CW'(1);
  localparam logic signed [DW+1:0] OFFSET_S = (DW+2)'(OFFSET);
  localparam logic signed [DW+1:0] FULL_S   = (DW+2)'(1 << CW);
  localparam duty_t                FULL_D   = duty_t'(1 << CW);

  function automatic duty_t sat_duty(input logic signed [DW-1:0] sample);
    logic signed [DW+1:0] d;
    d = sample;
    d = d + OFFSET_S;
    if (d[DW+1])
      return '0;
    else if (d > FULL_S)
      return FULL_D;
    else
      return d[CW:0];
  endfunction

  logic [CW-1:0]       cnt_p0;
  logic                dir_up;
  logic                mode_act;
  logic                pending;
  duty_t               shadow   [CHANNELS];
  duty_t               active   [CHANNELS];
  duty_t               new_duty [CHANNELS];
  duty_t               duty_eff [CHANNELS];
  logic                ps_p0;
  logic                mode_eff;
  logic                ovr_set;
  logic [CHANNELS-1:0] pwm_p1;
  logic                ps_p1;
  logic                ovr;

  // Stage 0: duty conversion, period-start detection and the bypass mux
  always_comb begin
    ps_p0    = bus.Enable && (cnt_p0 == '0) && dir_up;
    mode_eff = ps_p0 ? bus.Mode : mode_act;
    ovr_set  = bus.DataValid && pending;
    for (int k = 0; k < CHANNELS; k++) begin
      new_duty[k] = sat_duty(bus.DataIn[k*DW +: DW]);
      duty_eff[k] = active[k];
      if (ps_p0) begin
        if (bus.DataValid)
          duty_eff[k] = new_duty[k];
        else if (pending)
          duty_eff[k] = shadow[k];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_p0 <= '0;
      dir_up <= 1'b1;
    end else if (!bus.Enable) begin
      cnt_p0 <= '0;
      dir_up <= 1'b1;
    end else if (!mode_eff) begin
      cnt_p0 <= cnt_p0 + CNT_ONE;
      dir_up <= 1'b1;
    end else if (dir_up) begin
      if (cnt_p0 == CNT_MAX) begin
        cnt_p0 <= CNT_MAX - CNT_ONE;
        dir_up <= 1'b0;
      end else begin
        cnt_p0 <= cnt_p0 + CNT_ONE;
      end
    end else begin
      cnt_p0 <= cnt_p0 - CNT_ONE;
      if (cnt_p0 == CNT_ONE)
        dir_up <= 1'b1;
    end
  end

  // A word arriving on the period-start cycle skips the shadow entirely
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mode_act <= 1'b0;
      pending  <= 1'b0;
      shadow   <= '{default: '0};
      active   <= '{default: '0};
      ovr      <= 1'b0;
    end else begin
      if (ps_p0) begin
        mode_act <= bus.Mode;
        if (bus.DataValid || pending) begin
          active  <= duty_eff;
          pending <= 1'b0;
        end
      end else if (bus.DataValid) begin
        shadow  <= new_duty;
        pending <= 1'b1;
      end
      ovr <= ovr_set | (ovr & ~bus.OverrunClr);
    end
  end

  // Stage 1: registered outputs, one cycle behind the counter
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pwm_p1 <= '0;
      ps_p1  <= 1'b0;
    end else begin
      for (int k = 0; k < CHANNELS; k++)
        pwm_p1[k] <= bus.Enable && ({1'b0, cnt_p0} < duty_eff[k]);
      ps_p1 <= ps_p0;
    end
  end

  assign bus.PWMOut      = pwm_p1;
  assign bus.PeriodStart = ps_p1;
  assign bus.Overrun     = ovr;

endmodule
